// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with a show-ahead RX FIFO.
// Each word carries parity/framing error tags; overrun and break are sticky flags.
module uart_rx_fifo #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 1,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          baud_div,
   input  logic                 rx,
   input  logic                 rd_en,
   input  logic                 err_clr,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   output logic                 PE,
   output logic                 FE,
   output logic                 OE,
   output logic                 BE,
   output logic [CNT_W-1:0]     count
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
   localparam int unsigned WORD_W = DATA_BITS + 2;

   typedef enum logic [2:0] {
      StIdle, StStart, StData, StPar, StStop, StBrkWait
   } state_e;

   logic rx_meta, rxs;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // Divider is latched at the wrap so a baud_div change never truncates a tick period.
   logic [15:0] tick_cnt, div_q;
   logic        tick;

   assign tick = (tick_cnt == div_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
         div_q    <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
         div_q    <= baud_div;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   state_e               state;
   logic [SAMP_W-1:0]    samp_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_q, ferr_q, stop0_q;

   logic sample_now, last_stop, is_break, push, perr_w, ferr_w;

   always_comb begin
      sample_now = tick && (samp_cnt == SAMP_W'(OVERSAMPLE - 1));
      last_stop  = sample_now && (state == StStop) &&
                   ((STOP_BITS == 1) || stop_cnt);
      perr_w     = (PARITY == 0) ? 1'b0 : (par_q ^ (^shreg) ^ (PARITY == 2));
      ferr_w     = ferr_q | ~rxs;
      is_break   = last_stop && (shreg == '0) && ((PARITY == 0) || !par_q) &&
                   stop0_q && !rxs;
      push       = last_stop && !is_break;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= StIdle;
         samp_cnt <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         par_q    <= 1'b0;
         ferr_q   <= 1'b0;
         stop0_q  <= 1'b1;
      end else if (tick) begin
         unique case (state)
            StIdle: begin
               samp_cnt <= '0;
               if (!rxs) state <= StStart;
            end
            StStart: begin
               if (samp_cnt == SAMP_W'(OVERSAMPLE / 2 - 1)) begin
                  samp_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= rxs ? StIdle : StData;
               end else begin
                  samp_cnt <= samp_cnt + 1'b1;
               end
            end
            StData: begin
               if (sample_now) begin
                  samp_cnt <= '0;
                  shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                     state    <= (PARITY != 0) ? StPar : StStop;
                     stop_cnt <= 1'b0;
                     ferr_q   <= 1'b0;
                     stop0_q  <= 1'b1;
                  end
               end else begin
                  samp_cnt <= samp_cnt + 1'b1;
               end
            end
            StPar: begin
               if (sample_now) begin
                  samp_cnt <= '0;
                  par_q    <= rxs;
                  state    <= StStop;
               end else begin
                  samp_cnt <= samp_cnt + 1'b1;
               end
            end
            StStop: begin
               if (sample_now) begin
                  samp_cnt <= '0;
                  ferr_q   <= ferr_w;
                  stop0_q  <= stop0_q & ~rxs;
                  stop_cnt <= 1'b1;
                  // A low final stop bit may be the head of a held-low line.
                  if (last_stop) state <= rxs ? StIdle : StBrkWait;
               end else begin
                  samp_cnt <= samp_cnt + 1'b1;
               end
            end
            StBrkWait: begin
               if (rxs) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [WORD_W-1:0] head;
   logic [PTR_W-1:0]  wptr, rptr;
   logic              pop, full, wr, oe_set;

   always_comb begin
      pop    = rd_en && valid;
      full   = (count == CNT_W'(FIFO_DEPTH));
      wr     = push && (!full || pop);
      oe_set = push && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= {perr_w, ferr_w, shreg};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         OE    <= 1'b0;
         BE    <= 1'b0;
      end else begin
         if (wr)  wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (wr && !pop)      count <= count + 1'b1;
         else if (!wr && pop) count <= count - 1'b1;
         if (oe_set)       OE <= 1'b1;
         else if (err_clr) OE <= 1'b0;
         if (is_break)     BE <= 1'b1;
         else if (err_clr) BE <= 1'b0;
      end
   end

   assign valid    = (count != '0);
   assign head     = mem[rptr];
   assign data_out = valid ? head[DATA_BITS-1:0] : '0;
   assign FE       = valid & head[DATA_BITS];
   assign PE       = valid & head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench for uart_rx_fifo: frames are driven serially, expected words
// are queued at launch and a negedge monitor pops and compares the FIFO head.
module tb_uart_rx_fifo;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] baud_div = 16'd0;
   logic        rx = 1'b1;
   logic        rd_en = 1'b0;
   logic        err_clr = 1'b0;
   logic [7:0]  data_out;
   logic        valid, PE, FE, OE, BE;
   logic [3:0]  count;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic [9:0] exp_q [$];
   bit   auto_pop = 1'b0;
   bit   exp_oe = 1'b0;
   bit   exp_be = 1'b0;

   uart_rx_fifo dut (
      .clk      (clk),
      .rst      (rst),
      .baud_div (baud_div),
      .rx       (rx),
      .rd_en    (rd_en),
      .err_clr  (err_clr),
      .data_out (data_out),
      .valid    (valid),
      .PE       (PE),
      .FE       (FE),
      .OE       (OE),
      .BE       (BE),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare the show-ahead head with the scoreboard, then pop it.
   always @(negedge clk) begin
      if (rd_en) begin
         rd_en = 1'b0;
      end else if (auto_pop && valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h expected none", {PE, FE, data_out});
         end else begin
            check("rx_word {pe,fe,data}", {22'd0, PE, FE, data_out}, {22'd0, exp_q.pop_front()});
         end
         rd_en = 1'b1;
      end
   end

   function automatic logic even_par(input logic [7:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   task automatic drive_bit(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      int bc;
      bc = 16 * (int'(baud_div) + 1);
      if (d == 8'd0 && !par && !stop) exp_be = 1'b1;
      else if (!auto_pop && exp_q.size() >= DEPTH) exp_oe = 1'b1;
      else exp_q.push_back({par != even_par(d), !stop, d});
      drive_bit(1'b0, bc);
      for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
      drive_bit(par, bc);
      drive_bit(stop, bc);
      drive_bit(1'b1, 2 * bc);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 3000 && (exp_q.size() != 0 || valid); i++) @(negedge clk);
      check("drain_queue", exp_q.size(), 0);
      check("drain_valid", valid, 0);
   endtask

   task automatic pulse_clr();
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] d;
      logic       p, s;

      repeat (3) @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_count", count, 0);
      check("rst_data", data_out, 0);
      check("rst_pe_fe", {PE, FE}, 0);
      check("rst_oe_be", {OE, BE}, 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // Single good frame, held in the FIFO for direct inspection.
      send_frame(8'hA5, even_par(8'hA5), 1'b1);
      check("a5_valid", valid, 1);
      check("a5_count", count, 1);
      check("a5_data", data_out, 8'hA5);
      check("a5_pe_fe", {PE, FE}, 0);
      auto_pop = 1'b1;
      wait_drain();
      check("a5_count_after_pop", count, 0);

      // Parity error, then framing error.
      send_frame(8'h01, 1'b0, 1'b1);
      send_frame(8'h3C, even_par(8'h3C), 1'b0);
      wait_drain();

      // Break: line held low for 20 bit times.
      rx = 1'b0;
      repeat (20 * 16) @(negedge clk);
      rx = 1'b1;
      repeat (32) @(negedge clk);
      check("brk_be", BE, 1);
      check("brk_count", count, 0);
      pulse_clr();
      check("brk_be_cleared", BE, 0);

      // Overrun with no reads.
      auto_pop = 1'b0;
      for (int i = 0; i < 9; i++) send_frame(8'(i), even_par(8'(i)), 1'b1);
      check("ovr_count", count, DEPTH);
      check("ovr_oe", OE, exp_oe);
      auto_pop = 1'b1;
      wait_drain();
      pulse_clr();
      exp_oe = 1'b0;
      check("ovr_oe_cleared", OE, 0);

      // Short glitch must not start a frame.
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (64) @(negedge clk);
      check("glitch_count", count, 0);
      check("glitch_valid", valid, 0);

      // Slower bit rate: 64 clocks per bit.
      baud_div = 16'd3;
      repeat (8) @(negedge clk);
      send_frame(8'h5A, even_par(8'h5A), 1'b1);
      wait_drain();
      baud_div = 16'd0;
      repeat (8) @(negedge clk);

      // Random frames with occasional parity/framing errors and breaks.
      for (int n = 0; n < 20; n++) begin
         d = 8'($urandom);
         p = even_par(d) ^ ($urandom_range(0, 3) == 0);
         s = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 7) == 0) begin
            d = 8'd0;
            p = 1'b0;
            s = 1'b0;
         end
         send_frame(d, p, s);
      end
      wait_drain();
      check("rand_be", BE, exp_be);
      check("rand_oe", OE, exp_oe);
      pulse_clr();
      exp_be = 1'b0;

      // Reset in the middle of the data bits.
      rx = 1'b0;
      repeat (16) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
      rx = 1'b0;
      repeat (24) @(negedge clk);
      rst = 1'b0;
      rx = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (200) @(negedge clk);
      check("midrst_count", count, 0);
      check("midrst_valid", valid, 0);
      send_frame(8'hC3, even_par(8'hC3), 1'b1);
      wait_drain();
      check("midrst_oe_be", {OE, BE}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
